// File: rtl/capture_pkg.sv
// Shared definitions for the capture path: drain FSM states, frame marker
// and the writer's one-hot state codes.
package capture_pkg;

    typedef enum logic [9:0] {
        ST_IDLE     = 10'b00_0000_0001,
        ST_HDR      = 10'b00_0000_0010,
        ST_LEN_HI   = 10'b00_0000_0100,
        ST_LEN_LO   = 10'b00_0000_1000,
        ST_FETCH    = 10'b00_0001_0000,
        ST_LATCH    = 10'b00_0010_0000,
        ST_SEND_HI  = 10'b00_0100_0000,
        ST_SEND_LO  = 10'b00_1000_0000,
        ST_CKSUM    = 10'b01_0000_0000,
        ST_WAIT_REL = 10'b10_0000_0000
    } drain_state_t;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    // Writer state codes, so capture_done can be derived as (wr_state == WR_PAUSE).
    localparam logic [2:0] WR_INIT   = 3'b001;
    localparam logic [2:0] WR_BUFFER = 3'b010;
    localparam logic [2:0] WR_PAUSE  = 3'b100;

endpackage

// File: rtl/capture_drain.sv
// Drains a full capture FIFO into a framed byte stream:
// header, 16-bit length, samples MSB-first, XOR checksum (tlast).
module capture_drain
    import capture_pkg::*;
#(
    parameter int         SAMPLE_W      = 16,
    parameter int         FRAME_SAMPLES = 1024,
    parameter logic [7:0] HDR_BYTE      = HDR_BYTE_DEFAULT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                capture_done,
    input  logic                fifo_empty,
    input  logic [SAMPLE_W-1:0] fifo_dout,
    output logic                fifo_rd_en,
    output logic [7:0]          m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic                busy,
    output logic                underrun
);

    localparam logic [15:0] FRAME_LEN = 16'(FRAME_SAMPLES);

    drain_state_t state;
    logic [7:0]   cksum;
    logic [15:0]  count;
    logic [7:0]   sample_lo;
    logic         xfer;
    logic [15:0]  count_next;

    assign xfer       = m_tvalid && m_tready;
    assign count_next = count + 16'd1;

    // The read strobe is decoded from state so that read data lands exactly
    // in LATCH, keeping the per-sample cost at four cycles.
    assign fifo_rd_en = (state == ST_FETCH) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            m_tdata   <= 8'h00;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
            cksum     <= 8'h00;
            count     <= 16'h0000;
            sample_lo <= 8'h00;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (capture_done) begin
                        state    <= ST_HDR;
                        m_tdata  <= HDR_BYTE;
                        m_tvalid <= 1'b1;
                        busy     <= 1'b1;
                        cksum    <= 8'h00;
                        count    <= 16'h0000;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        state   <= ST_LEN_HI;
                        m_tdata <= FRAME_LEN[15:8];
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        state   <= ST_LEN_LO;
                        cksum   <= cksum ^ m_tdata;
                        m_tdata <= FRAME_LEN[7:0];
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        state    <= ST_FETCH;
                        cksum    <= cksum ^ m_tdata;
                        m_tvalid <= 1'b0;
                    end
                end
                // An empty FIFO here means the writer under-delivered; pad with zeros
                // so the frame still matches its header.
                ST_FETCH: begin
                    if (!fifo_empty) begin
                        state <= ST_LATCH;
                    end else begin
                        state     <= ST_SEND_HI;
                        underrun  <= 1'b1;
                        sample_lo <= 8'h00;
                        m_tdata   <= 8'h00;
                        m_tvalid  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    state     <= ST_SEND_HI;
                    sample_lo <= fifo_dout[7:0];
                    m_tdata   <= fifo_dout[15:8];
                    m_tvalid  <= 1'b1;
                end
                ST_SEND_HI: begin
                    if (xfer) begin
                        state   <= ST_SEND_LO;
                        cksum   <= cksum ^ m_tdata;
                        m_tdata <= sample_lo;
                    end
                end
                ST_SEND_LO: begin
                    if (xfer) begin
                        cksum <= cksum ^ m_tdata;
                        count <= count_next;
                        if (count_next == FRAME_LEN) begin
                            state   <= ST_CKSUM;
                            m_tdata <= cksum ^ m_tdata;
                            m_tlast <= 1'b1;
                        end else begin
                            state    <= ST_FETCH;
                            m_tvalid <= 1'b0;
                        end
                    end
                end
                ST_CKSUM: begin
                    if (xfer) begin
                        state    <= ST_WAIT_REL;
                        m_tvalid <= 1'b0;
                        m_tlast  <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                // Hold off re-triggering until the writer leaves its pause state.
                ST_WAIT_REL: begin
                    if (!capture_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_drain.sv
// Randomised bench for capture_drain: a queue FIFO model, a byte monitor and
// a frame-level reference model built from the framing rules.
module tb_capture_drain;

    localparam int FS = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        capture_done = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_dout = 16'h0000;
    logic        fifo_rd_en;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic        busy;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] cur_words[$];
    logic [7:0]  got_bytes[$];
    logic        got_last[$];
    logic [7:0]  exp_bytes[$];

    int   rd_count = 0;
    int   rd_viol = 0;
    int   stab_err = 0;
    int   rd_first_pos = -1;
    bit   frame_done = 0;
    bit   rand_ready = 0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_last = 1'b0;
    logic prev_rd = 1'b0;
    logic [7:0] prev_data = 8'h00;

    capture_drain #(
        .SAMPLE_W(16),
        .FRAME_SAMPLES(FS),
        .HDR_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .capture_done(capture_done),
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast(m_tlast),
        .busy(busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Standard-mode FIFO: data appears the cycle after a read strobe.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_dout  <= fifo_q.pop_front();
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) m_tready = ($urandom_range(0, 1) == 1);
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (m_tvalid && m_tready) begin
                got_bytes.push_back(m_tdata);
                got_last.push_back(m_tlast);
                if (m_tlast) frame_done = 1;
            end
            if (fifo_rd_en) begin
                rd_count++;
                if (rd_first_pos < 0) rd_first_pos = got_bytes.size();
                if (fifo_empty || prev_rd) rd_viol++;
            end
            if (prev_valid && !prev_ready &&
                !(m_tvalid && m_tdata == prev_data && m_tlast == prev_last)) stab_err++;
        end
        prev_valid = rstn && m_tvalid;
        prev_ready = m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        prev_rd    = rstn && fifo_rd_en;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // Reference frame: marker, length, FS samples (zero-padded past the
    // available words), then XOR of everything after the marker.
    function automatic void build_expected();
        logic [15:0] len;
        logic [15:0] w;
        logic [7:0]  x;
        len = 16'(FS);
        exp_bytes.delete();
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(len[15:8]);
        exp_bytes.push_back(len[7:0]);
        x = len[15:8] ^ len[7:0];
        for (int i = 0; i < FS; i++) begin
            w = (i < cur_words.size()) ? cur_words[i] : 16'h0000;
            exp_bytes.push_back(w[15:8]);
            exp_bytes.push_back(w[7:0]);
            x = x ^ w[15:8] ^ w[7:0];
        end
        exp_bytes.push_back(x);
    endfunction

    function automatic int frame_mismatch();
        build_expected();
        for (int i = 0; i < exp_bytes.size(); i++) begin
            if (i >= got_bytes.size()) return i;
            if (got_bytes[i] !== exp_bytes[i]) return i;
            if (got_last[i] !== (i == exp_bytes.size() - 1)) return i;
        end
        if (got_bytes.size() > exp_bytes.size()) return exp_bytes.size();
        return -1;
    endfunction

    function automatic logic [7:0] got_at(int i);
        return (i >= 0 && i < got_bytes.size()) ? got_bytes[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] exp_at(int i);
        return (i >= 0 && i < exp_bytes.size()) ? exp_bytes[i] : 8'hxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_bytes.delete();
        got_last.delete();
        rd_count = 0;
        rd_viol = 0;
        stab_err = 0;
        rd_first_pos = -1;
        frame_done = 0;
    endtask

    task automatic load_words();
        fifo_q.delete();
        foreach (cur_words[i]) fifo_q.push_back(cur_words[i]);
        fifo_empty = (cur_words.size() == 0);
    endtask

    task automatic random_words(input int n);
        cur_words.delete();
        for (int i = 0; i < n; i++) cur_words.push_back(16'($urandom));
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (!frame_done && n < 3000) begin
            tick(1);
            n++;
        end
        tick(2);
        checks++;
        if (!frame_done) begin
            errors++;
            $display("[TB] FAIL %s_timeout: frame_done %0b, required 1", name, frame_done);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(2);
        checks++;
        if ({m_tvalid, m_tlast, busy, underrun, fifo_rd_en} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %05b, required 00000",
                     {m_tvalid, m_tlast, busy, underrun, fifo_rd_en});
        end
        checks++;
        if (m_tdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_tdata: got %02h, required 00", m_tdata);
        end
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic test_basic();
        int mm;
        cur_words = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};
        load_words();
        clear_mon();
        m_tready = 1'b1;
        capture_done = 1'b1;
        wait_frame("basic");
        mm = frame_mismatch();
        checks++;
        if (mm != -1) begin
            errors++;
            $display("[TB] FAIL basic_frame: byte %0d got %02h, required %02h (got %0d bytes, required %0d)",
                     mm, got_at(mm), exp_at(mm), got_bytes.size(), exp_bytes.size());
        end
        checks++;
        if (rd_count !== 4 || rd_viol !== 0) begin
            errors++;
            $display("[TB] FAIL basic_reads: got %0d reads/%0d bad, required 4/0", rd_count, rd_viol);
        end
        checks++;
        if ({fifo_empty, underrun, busy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL basic_status: empty/underrun/busy got %03b, required 100",
                     {fifo_empty, underrun, busy});
        end
    endtask

    task automatic test_rearm();
        int mm;
        clear_mon();
        tick(20);
        checks++;
        if (got_bytes.size() !== 0 || m_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rearm_park: got %0d bytes valid %b busy %b, required 0 0 0",
                     got_bytes.size(), m_tvalid, busy);
        end
        capture_done = 1'b0;
        tick(2);
        random_words(FS);
        load_words();
        clear_mon();
        capture_done = 1'b1;
        wait_frame("rearm");
        mm = frame_mismatch();
        checks++;
        if (mm != -1) begin
            errors++;
            $display("[TB] FAIL rearm_frame: byte %0d got %02h, required %02h",
                     mm, got_at(mm), exp_at(mm));
        end
        capture_done = 1'b0;
        tick(2);
    endtask

    task automatic test_backpressure();
        int mm;
        cur_words = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};
        load_words();
        clear_mon();
        rand_ready = 1;
        capture_done = 1'b1;
        wait_frame("backpressure");
        rand_ready = 0;
        m_tready = 1'b1;
        mm = frame_mismatch();
        checks++;
        if (mm != -1) begin
            errors++;
            $display("[TB] FAIL bp_frame: byte %0d got %02h, required %02h",
                     mm, got_at(mm), exp_at(mm));
        end
        checks++;
        if (stab_err !== 0) begin
            errors++;
            $display("[TB] FAIL bp_stable: got %0d unstable holds, required 0", stab_err);
        end
        checks++;
        if (rd_count !== 4 || rd_viol !== 0) begin
            errors++;
            $display("[TB] FAIL bp_reads: got %0d reads/%0d bad, required 4/0", rd_count, rd_viol);
        end
        capture_done = 1'b0;
        tick(2);
    endtask

    task automatic test_underrun();
        int mm;
        cur_words = '{16'h1111, 16'h2222};
        load_words();
        clear_mon();
        m_tready = 1'b1;
        capture_done = 1'b1;
        wait_frame("underrun");
        mm = frame_mismatch();
        checks++;
        if (mm != -1) begin
            errors++;
            $display("[TB] FAIL underrun_frame: byte %0d got %02h, required %02h",
                     mm, got_at(mm), exp_at(mm));
        end
        checks++;
        if (underrun !== 1'b1 || rd_count !== 2 || rd_viol !== 0) begin
            errors++;
            $display("[TB] FAIL underrun_flag: got underrun %b reads %0d bad %0d, required 1 2 0",
                     underrun, rd_count, rd_viol);
        end
        capture_done = 1'b0;
        tick(2);
        random_words(FS);
        load_words();
        clear_mon();
        capture_done = 1'b1;
        wait_frame("underrun_sticky");
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underrun_sticky: got %b, required 1", underrun);
        end
        capture_done = 1'b0;
        tick(2);
    endtask

    task automatic test_mid_reset();
        int n;
        int mm;
        random_words(FS);
        load_words();
        clear_mon();
        m_tready = 1'b1;
        capture_done = 1'b1;
        n = 0;
        while (got_bytes.size() < 7 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (got_bytes.size() < 7) begin
            errors++;
            $display("[TB] FAIL midreset_reach: got %0d bytes, required 7", got_bytes.size());
        end
        rstn = 1'b0;
        capture_done = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        checks++;
        if ({m_tvalid, m_tlast, busy, underrun, fifo_rd_en} !== 5'b0 || m_tdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: flags %05b tdata %02h, required 00000 00",
                     {m_tvalid, m_tlast, busy, underrun, fifo_rd_en}, m_tdata);
        end
        fifo_q.delete();
        fifo_empty = 1'b1;
        clear_mon();
        tick(5);
        checks++;
        if (got_bytes.size() !== 0 || rd_count !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_quiet: got %0d bytes %0d reads, required 0 0",
                     got_bytes.size(), rd_count);
        end
        random_words(FS);
        load_words();
        capture_done = 1'b1;
        wait_frame("midreset_restart");
        mm = frame_mismatch();
        checks++;
        if (mm != -1 || underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_restart: mismatch at %0d underrun %b, required -1 0",
                     mm, underrun);
        end
        capture_done = 1'b0;
        tick(2);
    endtask

    task automatic test_hdr_stall();
        int hold_err;
        int mm;
        random_words(FS);
        load_words();
        clear_mon();
        m_tready = 1'b0;
        capture_done = 1'b1;
        tick(2);
        hold_err = 0;
        for (int i = 0; i < 50; i++) begin
            if (!(m_tvalid === 1'b1 && m_tdata === 8'hA5 && busy === 1'b1)) hold_err++;
            tick(1);
        end
        checks++;
        if (hold_err !== 0 || rd_count !== 0) begin
            errors++;
            $display("[TB] FAIL stall_hold: got %0d bad cycles %0d reads, required 0 0",
                     hold_err, rd_count);
        end
        m_tready = 1'b1;
        wait_frame("stall");
        mm = frame_mismatch();
        checks++;
        if (mm != -1 || rd_first_pos < 3) begin
            errors++;
            $display("[TB] FAIL stall_frame: mismatch at %0d first read after %0d bytes, required -1 and >=3",
                     mm, rd_first_pos);
        end
        capture_done = 1'b0;
        tick(2);
    endtask

    task automatic test_random();
        int  mm;
        int  n;
        bit  sticky;
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        sticky = 0;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(0, FS);
            random_words(n);
            load_words();
            clear_mon();
            rand_ready = 1;
            capture_done = 1'b1;
            wait_frame("random");
            rand_ready = 0;
            m_tready = 1'b1;
            if (n < FS) sticky = 1;
            mm = frame_mismatch();
            checks++;
            if (mm != -1) begin
                errors++;
                $display("[TB] FAIL random_frame%0d: byte %0d got %02h, required %02h",
                         f, mm, got_at(mm), exp_at(mm));
            end
            checks++;
            if (underrun !== sticky || rd_count !== n || rd_viol !== 0 || stab_err !== 0) begin
                errors++;
                $display("[TB] FAIL random_status%0d: underrun %b reads %0d bad %0d unstable %0d, required %b %0d 0 0",
                         f, underrun, rd_count, rd_viol, stab_err, sticky, n);
            end
            capture_done = 1'b0;
            tick(2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rearm();
        test_backpressure();
        test_underrun();
        test_mid_reset();
        test_hdr_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
